// File: rtl/shift_pkg.sv
// Shared types and codes for the shift_seq register/control stage and its shifter.
package shift_pkg;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        CLR  = 3'd1,
        SHL  = 3'd2,
        SHR  = 3'd3,
        ROL  = 3'd4,
        ROR  = 3'd5,
        ASR  = 3'd6
    } op_e;

    localparam logic [1:0] H_PASS  = 2'b00;
    localparam logic [1:0] H_LEFT  = 2'b01;
    localparam logic [1:0] H_RIGHT = 2'b10;
    localparam logic [1:0] H_ZERO  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_valid(input logic [2:0] code);
        return (code <= 3'd6);
    endfunction

    // LOAD and CLR always take exactly one step regardless of amount.
    function automatic logic op_single(input logic [2:0] code);
        return (code == 3'd0) || (code == 3'd1);
    endfunction

endpackage

// File: rtl/Shifter1.sv
// Combinational one-position shifter: pass, shift left, shift right or zero.
module Shifter1
    import shift_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] F,
    input  logic [1:0]   H,
    input  logic         IL,
    input  logic         IR,
    output logic [N-1:0] S
);

    // Select the shifted view of F according to H.
    always_comb begin
        S = F;
        case (H)
            H_PASS:  S = F;
            H_LEFT:  S = {F[N-2:0], IL};
            H_RIGHT: S = {IR, F[N-1:1]};
            H_ZERO:  S = {N{1'b0}};
            default: S = F;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// Register plus control stage around Shifter1: runs multi-step shift/rotate/load/clear
// commands under a start/busy/done handshake.
module shift_seq
    import shift_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N) + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [CW-1:0] amount,
    input  logic [N-1:0]  din,
    input  logic          sin,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          busy,
    output logic          done
);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_e        state_r;
    state_e        state_s;
    op_e           op_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  din_r;
    logic [N-1:0]  q_r;
    logic          sout_r;
    logic          busy_r;
    logic          done_r;

    logic [1:0]    h_s;
    logic          il_s;
    logic          ir_s;
    logic          sout_s;
    logic [N-1:0]  s_s;

    Shifter1 #(.N(N)) u_shifter (
        .F  (q_r),
        .H  (h_s),
        .IL (il_s),
        .IR (ir_s),
        .S  (s_s)
    );

    // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!start) begin
                    state_s = IDLE;
                end else if (!op_valid(op)) begin
                    state_s = DONE;
                end else if ((amount == CNT_ZERO) && !op_single(op)) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            RUN: begin
                if (op_single(op_r) || (cnt_r == CNT_ONE)) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Shifter controls for one step; outside RUN the shifter passes q through.
    always_comb begin
        h_s    = H_PASS;
        il_s   = 1'b0;
        ir_s   = 1'b0;
        sout_s = sout_r;
        if (state_r == RUN) begin
            case (op_r)
                LOAD: h_s = H_PASS;
                CLR:  h_s = H_ZERO;
                SHL:  begin h_s = H_LEFT;  il_s = sin;      sout_s = q_r[N-1]; end
                SHR:  begin h_s = H_RIGHT; ir_s = sin;      sout_s = q_r[0];   end
                ROL:  begin h_s = H_LEFT;  il_s = q_r[N-1]; sout_s = q_r[N-1]; end
                ROR:  begin h_s = H_RIGHT; ir_s = q_r[0];   sout_s = q_r[0];   end
                ASR:  begin h_s = H_RIGHT; ir_s = q_r[N-1]; sout_s = q_r[0];   end
                default: h_s = H_PASS;
            endcase
        end else begin
            h_s = H_PASS;
        end
    end

    // State register with busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
        end
    end

    // Command latch, step counter and the q/sout data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= LOAD;
            cnt_r  <= CNT_ZERO;
            din_r  <= {N{1'b0}};
            q_r    <= {N{1'b0}};
            sout_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r  <= op_e'(op);
                        cnt_r <= amount;
                        din_r <= din;
                    end
                end
                RUN: begin
                    cnt_r  <= cnt_r - CNT_ONE;
                    q_r    <= (op_r == LOAD) ? din_r : s_s;
                    sout_r <= sout_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign q    = q_r;
    assign sout = sout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq (N=4) against an arithmetic reference model.
module tb_shift_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] op;
    logic [3:0] amount;
    logic [3:0] din;
    logic       sin;
    logic [3:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int total;
    int bad;

    logic [3:0] mq;
    logic       msout;

    shift_seq #(.N(4), .CW(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .amount (amount),
        .din    (din),
        .sin    (sin),
        .q      (q),
        .sout   (sout),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: one step of each command expressed as integer arithmetic.
    task automatic model_step(input int opc, input int dv, input int s);
        int qi;
        qi = int'(mq);
        case (opc)
            0: qi = dv & 15;
            1: qi = 0;
            2: begin msout = (qi >> 3) & 1; qi = ((qi << 1) | s) & 15; end
            3: begin msout = qi & 1; qi = (qi >> 1) | (s << 3); end
            4: begin msout = (qi >> 3) & 1; qi = ((qi << 1) | (qi >> 3)) & 15; end
            5: begin msout = qi & 1; qi = (qi >> 1) | ((qi & 1) << 3); end
            6: begin msout = qi & 1; qi = (qi >> 1) | (qi & 8); end
            default: qi = qi;
        endcase
        mq = qi[3:0];
    endtask

    // Issue one command and check every cycle until the handshake returns to idle.
    task automatic run_cmd(input int opc, input int amt, input int dv, input int sin_fix, input bit poke);
        int  steps;
        int  sv;
        bit  direct;
        @(negedge clk);
        start  = 1'b1;
        op     = opc[2:0];
        amount = amt[3:0];
        din    = dv[3:0];
        sin    = 1'($urandom_range(0, 1));
        @(negedge clk);
        start  = 1'b0;
        op     = 3'($urandom);
        amount = 4'($urandom);
        din    = 4'($urandom);
        direct = (opc > 6) || ((amt == 0) && (opc > 1));
        steps  = direct ? 0 : ((opc <= 1) ? 1 : amt);
        for (int i = 0; i < steps; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL run_hs op=%0d step=%0d busy=%b done=%b want busy=1 done=0", opc, i, busy, done);
            end
            sv  = (sin_fix >= 0) ? sin_fix : int'($urandom_range(0, 1));
            sin = sv[0];
            start = (poke && i == 1) ? 1'b1 : 1'b0;
            @(negedge clk);
            model_step(opc, dv, sv);
            total++;
            if (q !== mq || sout !== msout) begin
                bad++;
                $display("FAIL step op=%0d step=%0d q=%b sout=%b want q=%b sout=%b", opc, i, q, sout, mq, msout);
            end
        end
        start = poke ? 1'b1 : 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || q !== mq || sout !== msout) begin
            bad++;
            $display("FAIL done_pulse op=%0d amt=%0d done=%b busy=%b q=%b sout=%b want 1 0 %b %b",
                     opc, amt, done, busy, q, sout, mq, msout);
        end
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== mq) begin
            bad++;
            $display("FAIL after_done op=%0d done=%b busy=%b q=%b want 0 0 %b", opc, done, busy, q, mq);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (q !== 4'b0000 || sout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state q=%b sout=%b busy=%b done=%b want 0000 0 0 0", q, sout, busy, done);
        end
        rst_n = 1'b1;
        mq = 4'b0000;
        msout = 1'b0;
        run_cmd(0, 1, 15, -1, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; amount = 4'd3; sin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_midrun q=%b busy=%b done=%b want 0000 0 0", q, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq = 4'b0000;
        msout = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || q !== 4'b0000) begin
                bad++;
                $display("FAIL reset_no_done cyc=%0d done=%b busy=%b q=%b want 0 0 0000", i, done, busy, q);
            end
        end
    endtask

    task automatic test_load();
        run_cmd(0, 9, 11, -1, 1'b0);
        total++;
        if (q !== 4'b1011) begin
            bad++;
            $display("FAIL load_value q=%b want 1011", q);
        end
    endtask

    task automatic test_shl();
        run_cmd(2, 2, 0, 1, 1'b0);
        total++;
        if (q !== 4'b1111 || sout !== 1'b0) begin
            bad++;
            $display("FAIL shl_value q=%b sout=%b want 1111 0", q, sout);
        end
    endtask

    task automatic test_rotate();
        run_cmd(0, 1, 11, -1, 1'b0);
        run_cmd(5, 3, 0, -1, 1'b0);
        total++;
        if (q !== 4'b0111 || sout !== 1'b0) begin
            bad++;
            $display("FAIL ror_value q=%b sout=%b want 0111 0", q, sout);
        end
        run_cmd(4, 4, 0, -1, 1'b0);
        total++;
        if (q !== 4'b0111) begin
            bad++;
            $display("FAIL rol_value q=%b want 0111", q);
        end
    endtask

    task automatic test_asr();
        run_cmd(0, 0, 8, -1, 1'b0);
        run_cmd(6, 5, 0, -1, 1'b0);
        total++;
        if (q !== 4'b1111) begin
            bad++;
            $display("FAIL asr_value q=%b want 1111", q);
        end
    endtask

    task automatic test_back_to_back();
        run_cmd(3, 0, 0, -1, 1'b0);
        run_cmd(4, 6, 0, -1, 1'b1);
        run_cmd(7, 5, 0, -1, 1'b0);
        run_cmd(1, 0, 0, -1, 1'b0);
        total++;
        if (q !== 4'b0000) begin
            bad++;
            $display("FAIL clr_value q=%b want 0000", q);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), -1, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        start  = 1'b0;
        op     = 3'd0;
        amount = 4'd0;
        din    = 4'd0;
        sin    = 1'b0;
        test_reset();
        test_load();
        test_shl();
        test_rotate();
        test_asr();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
